// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALUOp selectors, ALU control codes and sequencer state encoding
package alu_ctrl_pkg;

  // ALUOp selectors from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_CUST  = 2'b11;

  // ALU control codes; the top zero-extends them to CTRL_W
  localparam logic [4:0] CODE_ADD    = 5'h00;
  localparam logic [4:0] CODE_SUB    = 5'h01;
  localparam logic [4:0] CODE_AND    = 5'h02;
  localparam logic [4:0] CODE_OR     = 5'h03;
  localparam logic [4:0] CODE_XOR    = 5'h04;
  localparam logic [4:0] CODE_SLT    = 5'h05;
  localparam logic [4:0] CODE_SLTU   = 5'h06;
  localparam logic [4:0] CODE_CUST0  = 5'h08;
  localparam logic [4:0] CODE_CUST1  = 5'h09;
  localparam logic [4:0] CODE_SLL    = 5'h0A;
  localparam logic [4:0] CODE_SRA    = 5'h0B;
  localparam logic [4:0] CODE_SRL    = 5'h0C;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // M-extension codes occupy 0x10..0x17, indexed directly by funct3
  function automatic logic [4:0] m_code(input logic [2:0] f3);
    return {2'b10, f3};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational ALUOp/funct decode to control code, M-op and illegal flags
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int M_EXT = 1
) (
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  input  logic       opb5,
  output logic [4:0] code,
  output logic       is_m,
  output logic       is_illegal
);

  // Decode; every path yields a defined code, undefined encodings fall back to ADD with the flag set
  always_comb begin
    code       = CODE_ADD;
    is_m       = 1'b0;
    is_illegal = 1'b0;
    case (ALUOp)
      ALUOP_ADD: code = CODE_ADD;
      ALUOP_SUB: code = CODE_SUB;
      ALUOP_RTYPE: begin
        if ((M_EXT != 0) && opb5 && funct7b0 && !funct7b5) begin
          is_m = 1'b1;
          code = m_code(funct3);
        end else begin
          case (funct3)
            3'b000:  code = (funct7b5 && opb5) ? CODE_SUB : CODE_ADD;
            3'b001:  code = CODE_SLL;
            3'b010:  code = CODE_SLT;
            3'b011:  code = CODE_SLTU;
            3'b100:  code = CODE_XOR;
            3'b101:  code = funct7b5 ? CODE_SRA : CODE_SRL;
            3'b110:  code = CODE_OR;
            default: code = CODE_AND;
          endcase
        end
      end
      default: begin
        case (funct3)
          3'b000:  code = CODE_CUST0;
          3'b001:  code = CODE_CUST1;
          default: is_illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// rtl/alu_ctrl_sequencer.sv - registered ALU-control stage with fixed-latency mul/div sequencing
module alu_ctrl_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W  = 5,
  parameter int M_EXT   = 1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              valid_i,
  input  logic [1:0]        ALUOp,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              funct7b0,
  input  logic              opb5,
  output logic [CTRL_W-1:0] alu_control,
  output logic              ctrl_valid,
  output logic              md_start,
  output logic [2:0]        md_op,
  output logic              stall,
  output logic              illegal
);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [CTRL_W-1:0] r_alu_control;
  logic              r_ctrl_valid;
  logic              r_md_start;
  logic [2:0]        r_md_op;
  logic              r_illegal;

  logic [4:0]        w_code;
  logic              w_is_m;
  logic              w_is_illegal;
  logic              w_accept;
  logic [3:0]        w_lat_m1;

  alu_ctrl_decode #(
    .M_EXT(M_EXT)
  ) u_decode (
    .ALUOp      (ALUOp),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .funct7b0   (funct7b0),
    .opb5       (opb5),
    .code       (w_code),
    .is_m       (w_is_m),
    .is_illegal (w_is_illegal)
  );

  // funct3[2] separates the DIV/REM family from the MUL family
  assign w_accept = valid_i && (r_state == ST_IDLE) && !flush;
  assign w_lat_m1 = funct3[2] ? 4'(DIV_LAT - 1) : 4'(MUL_LAT - 1);

  // FSM, down-counter and output registers; flush always beats accept and completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 4'd0;
      r_alu_control <= '0;
      r_ctrl_valid  <= 1'b0;
      r_md_start    <= 1'b0;
      r_md_op       <= 3'd0;
      r_illegal     <= 1'b0;
    end else begin
      r_ctrl_valid <= 1'b0;
      r_md_start   <= 1'b0;
      r_illegal    <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_accept) begin
          if (w_is_m) begin
            r_state    <= ST_BUSY;
            r_md_start <= 1'b1;
            r_md_op    <= funct3;
            r_cnt      <= w_lat_m1;
          end else begin
            r_alu_control <= CTRL_W'(w_code);
            r_ctrl_valid  <= 1'b1;
            r_illegal     <= w_is_illegal;
          end
        end
      end else begin
        if (flush) begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end else if (r_cnt == 4'd0) begin
          r_state       <= ST_IDLE;
          r_alu_control <= CTRL_W'(m_code(r_md_op));
          r_ctrl_valid  <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign alu_control = r_alu_control;
  assign ctrl_valid  = r_ctrl_valid;
  assign md_start    = r_md_start;
  assign md_op       = r_md_op;
  assign stall       = (r_state == ST_BUSY);
  assign illegal     = r_illegal;

endmodule
